uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx among N_REQ byte streams.
// Define UART_ARB_GAP_EN to insert GAP_CYCLES idle clocks after every message.
module uart_tx_arbiter #(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*N_REQ-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]   s_axis_tvalid,
  input  logic [N_REQ-1:0]   s_axis_tlast,
  output logic [N_REQ-1:0]   s_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [15:0]        msg_count
);

  // state   | meaning
  // IDLE    | no owner; arbitrate among valid requesters
  // XFER    | granted requester streams bytes straight through until tlast
  // GAP     | post-message quiet time, busy with no owner
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [15:0]      msg_count_q, msg_count_d;

  logic [IDX_W-1:0] rr_idx;
  logic             rr_hit;
  logic             beat;
  logic             tlast_beat;

`ifdef UART_ARB_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin : rr_pick
    int cand;
    cand   = 0;
    rr_idx = last_q;
    rr_hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_q) + i) % N_REQ;
      if (!rr_hit && s_axis_tvalid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin : datapath
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      m_axis_tdata          = s_axis_tdata[8*gidx_q +: 8];
      m_axis_tvalid         = s_axis_tvalid[gidx_q];
      s_axis_tready[gidx_q] = m_axis_tready;
    end
  end

  assign beat       = m_axis_tvalid && m_axis_tready;
  assign tlast_beat = beat && s_axis_tlast[gidx_q];

  always_comb begin : next_state
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    msg_count_d = msg_count_q;
`ifdef UART_ARB_GAP_EN
    gap_d       = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_hit) begin
          state_d         = ST_XFER;
          gidx_d          = rr_idx;
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
        end
      end
      ST_XFER: begin
        if (tlast_beat) begin
          msg_count_d = msg_count_q + 16'd1;
          last_d      = gidx_q;
          grant_d     = '0;
`ifdef UART_ARB_GAP_EN
          state_d     = ST_GAP;
          gap_d       = GAP_W'(GAP_CYCLES - 1);
`else
          state_d     = ST_IDLE;
`endif
        end
      end
`ifdef UART_ARB_GAP_EN
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      msg_count_q <= 16'd0;
`ifdef UART_ARB_GAP_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      msg_count_q <= msg_count_d;
`ifdef UART_ARB_GAP_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign msg_count = msg_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: source queues drive requesters, a scoreboard checks
// every byte and message owner at the UART side; table of round-robin vectors.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int GAP = 16;
`ifdef UART_ARB_GAP_EN
  localparam int EXP_GAP_BUSY = GAP;
`else
  localparam int EXP_GAP_BUSY = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [N-1:0] mask;
    int           first;
    int           second;
    int           third;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic [8*N-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [15:0]    msg_count;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .grant        (grant),
    .busy         (busy),
    .msg_count    (msg_count)
  );

  int checks = 0;
  int errors = 0;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  int    exp_owner [$];

  logic [N-1:0] hs_q = '0;
  int  rdy_mode = 0;
  int  cyc = 0;
  int  xfer_cnt = 0;
  int  done_cnt = 0;
  int  stall_cnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic in_msg = 1'b0;
  int  cur_owner = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = i;
        c++;
      end
    end
    return (c == 1) ? r : -1;
  endfunction

  function automatic bit src_empty();
    bit e = 1'b1;
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() != 0) begin
        s_tvalid[k]        = 1'b1;
        s_tdata[8*k +: 8]  = src_q[k][0].data;
        s_tlast[k]         = src_q[k][0].last;
      end else begin
        s_tvalid[k]        = 1'b0;
        s_tdata[8*k +: 8]  = 8'h00;
        s_tlast[k]         = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[k].push_back(b);
    exp_q[k].push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while (!(src_empty() && !busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    exp_owner.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Source side: pop a beat after the edge it was accepted on, then re-present.
  initial begin : driver
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (hs_q[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
      cyc++;
      m_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
      drive_src();
    end
  end

  always @(negedge clk) begin : monitor
    int    g;
    beat_t e;
    logic [N-1:0] exp_rdy;
    hs_q    = rst_n ? (s_tvalid & s_tready) : '0;
    exp_rdy = m_tready ? grant : '0;
    chk("tready_route", s_tready, exp_rdy);
    if (!busy) begin
      chk("idle_tvalid", m_tvalid, 1'b0);
      chk("idle_grant", grant, '0);
    end
    if (grant == '0) chk("nogrant_tvalid", m_tvalid, 1'b0);
    if (rst_n && stall_prev) begin
      chk("stall_hold_valid", m_tvalid, 1'b1);
      chk("stall_hold_data", m_tdata, stall_data);
    end
    if (rst_n && m_tvalid && m_tready) begin
      g = oh_idx(grant);
      chk("beat_grant_onehot", g >= 0, 1'b1);
      if (g >= 0) begin
        chk("beat_expected", exp_q[g].size() != 0, 1'b1);
        if (exp_q[g].size() != 0) begin
          e = exp_q[g].pop_front();
          chk("beat_data", m_tdata, e.data);
          if (in_msg) chk("owner_stable", g, cur_owner);
          in_msg    = 1'b1;
          cur_owner = g;
          xfer_cnt++;
          if (e.last) begin
            in_msg = 1'b0;
            done_cnt++;
            chk("owner_queued", exp_owner.size() != 0, 1'b1);
            if (exp_owner.size() != 0) chk("msg_owner", g, exp_owner.pop_front());
          end
        end
      end
    end
    stall_prev = rst_n && m_tvalid && !m_tready;
    if (stall_prev) stall_cnt++;
    stall_data = m_tdata;
    if (!rst_n) in_msg = 1'b0;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [8];

  initial begin : main
    int n;
    int base;
    int gap_busy;
    int gap_zero;

    tbl[0] = '{3'b011, 0, 1, -1};
    tbl[1] = '{3'b101, 2, 0, -1};
    tbl[2] = '{3'b110, 1, 2, -1};
    tbl[3] = '{3'b111, 0, 1,  2};
    tbl[4] = '{3'b010, 1, -1, -1};
    tbl[5] = '{3'b001, 0, -1, -1};
    tbl[6] = '{3'b100, 2, -1, -1};
    tbl[7] = '{3'b110, 1, 2, -1};

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_grant", grant, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, '0);
    chk("rst_msg_count", msg_count, 16'd0);

    // "ABC" on requester 0
    push_beat(0, 8'h41, 1'b0);
    push_beat(0, 8'h42, 1'b0);
    push_beat(0, 8'h43, 1'b1);
    exp_owner.push_back(0);
    step();
    chk("abc_tvalid_up", s_tvalid[0], 1'b1);
    chk("abc_grant_pre", grant, '0);
    step();
    chk("abc_grant", grant, 3'b001);
    chk("abc_busy", busy, 1'b1);
    chk("abc_first_byte", m_tdata, 8'h41);
    wait_drained(100, "abc_drain");
    chk("abc_msg_count", msg_count, 16'd1);

    // Round-robin table
    do_reset();
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < N; k++)
        if (tbl[t].mask[k]) push_beat(k, 8'(16 * k + t), 1'b1);
      exp_owner.push_back(tbl[t].first);
      if (tbl[t].second >= 0) exp_owner.push_back(tbl[t].second);
      if (tbl[t].third >= 0) exp_owner.push_back(tbl[t].third);
      n = 0;
      while (grant == '0 && n < 20) begin
        step();
        n++;
      end
      chk("rr_first", grant, 3'b001 << tbl[t].first);
      wait_drained(300, "rr_drain");
    end

    // Contention: two 2-byte messages each on requesters 0 and 1
    do_reset();
    for (int m = 0; m < 2; m++) begin
      push_beat(0, 8'(8'hA0 + 2 * m), 1'b0);
      push_beat(0, 8'(8'hA1 + 2 * m), 1'b1);
      push_beat(1, 8'(8'hB0 + 2 * m), 1'b0);
      push_beat(1, 8'(8'hB1 + 2 * m), 1'b1);
    end
    exp_owner.push_back(0);
    exp_owner.push_back(1);
    exp_owner.push_back(0);
    exp_owner.push_back(1);
    wait_drained(300, "cont_drain");
    chk("cont_msg_count", msg_count, 16'd4);

    // Backpressure: 1 cycle ready, 3 cycles stalled
    rdy_mode = 1;
    base = xfer_cnt;
    n = stall_cnt;
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h33, 1'b0);
    push_beat(2, 8'h44, 1'b1);
    exp_owner.push_back(2);
    wait_drained(200, "bp_drain");
    chk("bp_transfers", xfer_cnt - base, 4);
    chk("bp_stalls_seen", stall_cnt > n, 1'b1);
    rdy_mode = 0;
    step();

    // Gap between back-to-back messages (last owner is 2, so 0 then 1)
    base = done_cnt;
    push_beat(0, 8'h5A, 1'b1);
    push_beat(1, 8'hA5, 1'b1);
    exp_owner.push_back(0);
    exp_owner.push_back(1);
    n = 0;
    while (done_cnt == base && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) timeout("gap_first_msg");
    gap_busy = 0;
    gap_zero = 0;
    n = 0;
    while (grant == '0 && n < GAP + 20) begin
      if (busy) gap_busy++;
      gap_zero++;
      step();
      n++;
    end
    chk("gap_busy_cycles", gap_busy, EXP_GAP_BUSY);
    chk("gap_nogrant_cycles", gap_zero, EXP_GAP_BUSY + 1);
    chk("gap_next_grant", grant, 3'b010);
    wait_drained(200, "gap_drain");

    // Reset after byte 2 of a 5-byte message; requester 1 is pending
    do_reset();
    for (int i = 0; i < 5; i++) push_beat(0, 8'(8'hC0 + i), i == 4);
    push_beat(1, 8'hD0, 1'b1);
    exp_owner.push_back(0);
    exp_owner.push_back(1);
    base = xfer_cnt;
    n = 0;
    while (xfer_cnt < base + 2 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout("mid_two_bytes");
    rst_n = 1'b0;
    src_q[0].delete();
    exp_q[0].delete();
    void'(exp_owner.pop_front());
    step();
    chk("mid_rst_grant", grant, '0);
    chk("mid_rst_msg_count", msg_count, 16'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_tvalid", m_tvalid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_post_winner", grant, 3'b010);
    wait_drained(100, "mid_drain");
    chk("mid_msg_count", msg_count, 16'd1);

    // Counter wrap: preload near the top, then complete messages
    force dut.msg_count_q = 16'hFFFE;
    step();
    step();
    release dut.msg_count_q;
    step();
    chk("wrap_preload", msg_count, 16'hFFFE);
    push_beat(0, 8'h01, 1'b1);
    exp_owner.push_back(0);
    wait_drained(100, "wrap_drain1");
    chk("wrap_ffff", msg_count, 16'hFFFF);
    push_beat(0, 8'h02, 1'b1);
    exp_owner.push_back(0);
    wait_drained(100, "wrap_drain2");
    chk("wrap_zero", msg_count, 16'h0000);

    chk("owners_left", exp_owner.size(), 0);
    for (int k = 0; k < N; k++) chk("bytes_left", exp_q[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
